// File: rtl/mu0_mem_pkg.sv
// Shared constants for the MU0 memory responder: I/O page addresses,
// status register bit positions and the UART transmitter state type.
package mu0_mem_pkg;

  localparam logic [11:0] ADDR_LED  = 12'hFF0;
  localparam logic [11:0] ADDR_TXD  = 12'hFF1;
  localparam logic [11:0] ADDR_STAT = 12'hFF2;
  localparam logic [11:0] ADDR_CNT  = 12'hFF3;

  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_BUSY  = 3;
  localparam int ST_OVF   = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/mu0_uart_tx.sv
// FIFO-buffered 8N1 serial transmitter: a circular byte FIFO feeding a
// start/data/stop serializer with a registered line output.
module mu0_uart_tx
  import mu0_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_DIV   = 434
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic       busy,
  input  logic       ovf_clr,
  output logic       ovf,
  output logic       uart_tx
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  tx_state_t     state;
  logic [BW-1:0] bcnt;
  logic [2:0]    bidx;
  logic [7:0]    shreg;
  logic          push_ok, pop, bit_end;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign busy    = (state != IDLE);
  assign push_ok = push && !full;
  assign pop     = (state == IDLE) && !empty;
  assign bit_end = (bcnt == BAUD_LAST);

  // Byte storage is pure data; only pointers and count need a defined start.
  always_ff @(posedge sysclk) begin
    if (push_ok) fifo[wptr] <= din;
    if (pop) shreg <= fifo[rptr];
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (push_ok && !pop) count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      // Full is judged before any same-cycle pop, so such a push is still lost.
      if (push && full) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state   <= IDLE;
      bcnt    <= '0;
      bidx    <= '0;
      uart_tx <= 1'b1;
    end else begin
      bcnt <= bit_end ? '0 : bcnt + 1'b1;
      unique case (state)
        IDLE: begin
          bcnt <= '0;
          if (pop) begin
            state   <= START;
            uart_tx <= 1'b0;
          end
        end
        START: if (bit_end) begin
          state   <= DATA;
          bidx    <= '0;
          uart_tx <= shreg[0];
        end
        DATA: if (bit_end) begin
          if (bidx == 3'd7) begin
            state   <= STOP;
            uart_tx <= 1'b1;
          end else begin
            bidx    <= bidx + 1'b1;
            uart_tx <= shreg[bidx + 1'b1];
          end
        end
        STOP: if (bit_end) state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mu0_mem_io.sv
// MU0 memory-bus responder: combinational-read RAM plus an I/O page with
// LED register, free-running cycle counter and buffered UART transmitter.
module mu0_mem_io
  import mu0_mem_pkg::*;
#(
  parameter logic [11:0] RAM_TOP    = 12'hFEF,
  parameter int          FIFO_DEPTH = 4,
  parameter int          BAUD_DIV   = 434
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        memRW,
  input  logic [11:0] address,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic [7:0]  led,
  output logic        uart_tx
);

  localparam int RAM_WORDS = int'(RAM_TOP) + 1;

  logic [15:0] ram [RAM_WORDS];
  logic [15:0] cnt, status;
  logic        in_ram, tx_push, ovf_clr;
  logic        full, empty, busy, ovf;

  assign in_ram  = (address <= RAM_TOP);
  assign tx_push = memRW && (address == ADDR_TXD);
  assign ovf_clr = memRW && (address == ADDR_STAT);

  always_ff @(posedge sysclk) begin
    if (memRW && in_ram) ram[address] <= writedata;
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      led <= '0;
      cnt <= '0;
    end else begin
      if (memRW && (address == ADDR_LED)) led <= writedata[7:0];
      // The load edge is also a counting edge, so the loaded value is already advanced.
      cnt <= (memRW && (address == ADDR_CNT)) ? writedata + 16'd1 : cnt + 16'd1;
    end
  end

  always_comb begin
    status           = '0;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY]  = busy;
    status[ST_OVF]   = ovf;
  end

  always_comb begin
    readdata = '0;
    if (in_ram) begin
      readdata = ram[address];
    end else begin
      case (address)
        ADDR_LED:  readdata = {8'h00, led};
        ADDR_STAT: readdata = status;
        ADDR_CNT:  readdata = cnt;
        default:   readdata = '0;
      endcase
    end
  end

  mu0_uart_tx #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .BAUD_DIV  (BAUD_DIV)
  ) u_tx (
    .sysclk (sysclk),
    .reset  (reset),
    .push   (tx_push),
    .din    (writedata[7:0]),
    .full   (full),
    .empty  (empty),
    .busy   (busy),
    .ovf_clr(ovf_clr),
    .ovf    (ovf),
    .uart_tx(uart_tx)
  );

endmodule

// File: tb/tb_mu0_mem_io.sv
// Bench for mu0_mem_io: an elapsed-time behavioural model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mu0_mem_io;

  localparam int B     = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memRW = 1'b0;
  logic [11:0] address = '0;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic [7:0]  led;
  logic        uart_tx;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mu0_mem_io #(.RAM_TOP(12'hFEF), .FIFO_DEPTH(DEPTH), .BAUD_DIV(B)) dut (
    .sysclk(clk), .reset(reset), .memRW(memRW), .address(address),
    .writedata(writedata), .readdata(readdata), .led(led), .uart_tx(uart_tx)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Model: RAM as a sparse map, FIFO as a queue, the line as a function of
  // the time elapsed since the current byte left the queue.
  logic [15:0] m_ram [int];
  logic [7:0]  m_q [$];
  logic [7:0]  m_led = '0;
  logic [7:0]  m_cur = '0;
  logic [15:0] m_cnt = '0;
  bit          m_ovf = 0, m_act = 0, m_valid = 0;
  int          m_el = 0;

  always @(posedge clk) begin : model
    int pre;
    pre = m_q.size();
    if (!reset) begin
      m_q.delete();
      m_act = 0; m_ovf = 0; m_led = '0; m_cnt = '0; m_valid = 1;
    end else begin
      if (m_act) begin
        m_el++;
        if (m_el == 10 * B) m_act = 0;
      end else if (pre > 0) begin
        m_cur = m_q.pop_front();
        m_act = 1;
        m_el  = 0;
      end
      if (memRW) begin
        if (address <= 12'hFEF) m_ram[int'(address)] = writedata;
        case (address)
          12'hFF0: m_led = writedata[7:0];
          12'hFF1: if (pre == DEPTH) m_ovf = 1; else m_q.push_back(writedata[7:0]);
          12'hFF2: m_ovf = 0;
          default: ;
        endcase
      end
      m_cnt = (memRW && address == 12'hFF3) ? writedata + 16'd1 : m_cnt + 16'd1;
    end
  end

  function automatic logic m_line();
    int k;
    if (!m_act) return 1'b1;
    k = m_el / B;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  function automatic logic [15:0] m_stat();
    return {11'b0, m_ovf, m_act, m_q.size() == 0, m_q.size() == DEPTH, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      check("line", uart_tx, m_line());
      check("led", led, m_led);
      if (address <= 12'hFEF) begin
        if (m_ram.exists(int'(address))) check("rd_ram", readdata, m_ram[int'(address)]);
      end else begin
        case (address)
          12'hFF0: check("rd_led", readdata, {8'h00, m_led});
          12'hFF2: check("rd_stat", readdata, m_stat());
          12'hFF3: check("rd_cnt", readdata, m_cnt);
          default: check("rd_zero", readdata, 16'h0000);
        endcase
      end
    end
  end

  // Independent serial receiver, sampling each bit at its centre.
  logic [7:0] rx_q [$];
  logic [7:0] rx_sh = '0;
  int         rx_ph = -1;

  always @(negedge clk) begin
    if (rx_ph < 0) begin
      if (uart_tx === 1'b0) rx_ph = 0;
    end else begin
      rx_ph++;
      if ((rx_ph % B) == B / 2 && rx_ph / B >= 1 && rx_ph / B <= 8) rx_sh[rx_ph / B - 1] = uart_tx;
      if (rx_ph == 9 * B + B / 2) begin
        rx_q.push_back(rx_sh);
        rx_ph = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [11:0] a, input logic [15:0] d);
    memRW = rw; address = a; writedata = d;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] fr;
    int n;

    drive(0, 12'hFF0, 16'h0000);
    tick(); tick();
    reset = 1'b1;
    #1 check("rst_led_rd", readdata, 16'h0000);
    address = 12'hFF2;
    #1 check("rst_stat", readdata, 16'h0004);
    address = 12'hFF1;
    #1 check("rst_txd", readdata, 16'h0000);
    check("rst_line", uart_tx, 16'h0001);

    tick(); drive(1, 12'h123, 16'hBEEF);
    tick(); drive(0, 12'h123, 16'h0000);
    #1 check("ram_rd", readdata, 16'hBEEF);
    address = 12'hFF8;
    #1 check("gap_rd", readdata, 16'h0000);

    tick(); drive(1, 12'hFF0, 16'h1234);
    tick(); drive(0, 12'hFF0, 16'h0000);
    #1 check("led_rd", readdata, 16'h0034);
    check("led_port", led, 16'h0034);

    tick(); drive(1, 12'hFF1, 16'h00A5);
    tick(); drive(0, 12'hFF2, 16'h0000);
    #1 check("tx_queued", readdata, 16'h0000);
    tick();
    #1 check("tx_busy", readdata, 16'h000C);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10 * B; i++) begin
      check("tx_bit", uart_tx, fr[i / B]);
      tick();
    end
    #1 check("tx_idle_line", uart_tx, 16'h0001);
    check("tx_done_stat", readdata, 16'h0004);

    rx_q.delete();
    for (int v = 1; v <= 5; v++) begin
      tick(); drive(1, 12'hFF1, 16'(v));
    end
    tick(); drive(0, 12'hFF2, 16'h0000);
    #1 check("ovf_full", readdata, 16'h000A);
    tick(); drive(1, 12'hFF1, 16'h0006);
    tick(); drive(0, 12'hFF2, 16'h0000);
    #1 check("ovf_set", readdata, 16'h001A);
    tick(); drive(1, 12'hFF2, 16'h0000);
    tick(); drive(0, 12'hFF2, 16'h0000);
    #1 check("ovf_clr", readdata, 16'h000A);
    n = 0;
    while ((rx_q.size() < 5 || readdata != 16'h0004) && n < 400) begin
      tick();
      n++;
    end
    check("ovf_drain_in_time", 16'(n < 400), 16'h0001);
    repeat (60) tick();
    check("ovf_frames", 16'(rx_q.size()), 16'h0005);
    if (rx_q.size() == 5)
      for (int i = 0; i < 5; i++) check("ovf_byte", rx_q[i], 16'(i + 1));

    tick(); drive(1, 12'hFF3, 16'hFFFE);
    tick(); drive(0, 12'hFF3, 16'h0000);
    #1 check("cnt_ffff", readdata, 16'hFFFF);
    tick();
    #1 check("cnt_wrap", readdata, 16'h0000);

    tick(); drive(1, 12'hFF1, 16'h0033);
    tick(); writedata = 16'h0044;
    tick(); writedata = 16'h0055;
    tick(); drive(0, 12'hFF2, 16'h0000);
    repeat (16) tick();
    #1 check("pre_rst_stat", readdata, 16'h0008);
    check("pre_rst_bit3", uart_tx, 16'h0000);
    reset = 1'b0;
    tick();
    #1 check("rst_line_hi", uart_tx, 16'h0001);
    reset = 1'b1;
    #1 check("rst_flush", readdata, 16'h0004);
    for (int i = 0; i < 60; i++) begin
      tick();
      check("rst_quiet", uart_tx, 16'h0001);
    end

    for (int c = 0; c < 2500; c++) begin
      tick();
      case ($urandom_range(0, 5))
        0: address = 12'h100 + 12'($urandom_range(0, 7));
        1: address = 12'hFEF;
        2: address = 12'hFF0 + 12'($urandom_range(0, 3));
        3: address = 12'hFF1;
        4: address = 12'hFF4 + 12'($urandom_range(0, 11));
        default: address = 12'hFF2;
      endcase
      memRW = ($urandom_range(0, 3) == 0);
      writedata = 16'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        memRW = 1'b0;
      end else begin
        reset = 1'b1;
      end
    end
    tick(); drive(0, 12'hFF2, 16'h0000);
    reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mu0_mem_io.md
Name: mu0_mem_io

Overview:
Memory-side responder for the MU0 CPU memory bus. It answers the processor's address/memRW/writedata/readdata transactions with on-chip RAM plus a small memory-mapped I/O page. The I/O page holds an LED register, a free-running cycle counter and a FIFO-buffered 8N1 UART transmitter. It drops in as the processor's memory instance, so MU0 programs get serial output and a timebase.

Parameters:
- RAM_TOP, 12'hFEF, highest RAM word address; RAM covers 0x000..RAM_TOP.
- FIFO_DEPTH, 4, UART TX FIFO entries; must be a power of two.
- BAUD_DIV, 434, sysclk cycles per UART bit (50 MHz / 115200).

Ports:
- sysclk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- memRW  in  1  1 = write this cycle, 0 = read.
- address  in  12  word address from the CPU address mux.
- writedata  in  16  write data from the CPU X mux.
- readdata  out  16  read data to the IR, ALU Y input and status paths.
- led  out  8  LED register value.
- uart_tx  out  1  serial line, idle high.

Behaviour:
- Bus timing
  - Reads are combinational: readdata follows address in the same cycle, because the MU0 FSM fetches in one cycle.
  - Writes commit on the rising edge when memRW=1.
  - Reads have no side effects.
- Address map
  - 0x000..RAM_TOP: RAM, read/write.
  - 0xFF0: LED. Write loads writedata[7:0]; read returns {8'h00, led}.
  - 0xFF1: TX data. Write pushes writedata[7:0] into the FIFO; read returns 0.
  - 0xFF2: status. Read returns {11'b0, ovf, tx_busy, empty, full, 1'b0}; bit1=full, bit2=empty, bit3=tx_busy, bit4=ovf. Any write clears ovf.
  - 0xFF3: cycle counter. Increments every cycle and wraps 0xFFFF->0x0000. A write loads writedata; the next cycle then reads writedata+1.
  - Gap between RAM_TOP+1 and 0xFEF, and 0xFF4..0xFFF: read 0, writes ignored.
- Reset values: led=0, uart_tx=1, counter=0, FIFO empty (count=0, pointers=0), ovf=0, TX FSM in IDLE. RAM contents are not cleared by reset.
- FIFO
  - Circular buffer with a count of 0..FIFO_DEPTH; full = (count==FIFO_DEPTH), empty = (count==0).
  - A push while full is dropped and sets ovf. This applies even if a pop happens in the same cycle, because full is judged on the pre-edge count.
  - A push and a pop in the same cycle while not full and not empty leaves count unchanged.
- TX FSM states: IDLE, START, DATA, STOP. Baud counter bcnt and bit index bidx.
  - IDLE: if FIFO not empty, pop the head into shreg and go to START, bcnt=0. uart_tx=1.
  - START: uart_tx=0 for BAUD_DIV cycles, then DATA with bidx=0.
  - DATA: uart_tx=shreg[bidx] for BAUD_DIV cycles per bit, LSB first. After bit 7, go to STOP.
  - STOP: uart_tx=1 for BAUD_DIV cycles, then IDLE. A queued byte therefore starts its start bit one cycle after STOP ends.
  - tx_busy = (state != IDLE).
  - Frame length is 10*BAUD_DIV cycles, plus 1 IDLE cycle between back-to-back frames.
- Reset asserted mid-frame: the FSM returns to IDLE, uart_tx goes high in the next cycle, and the FIFO is flushed.
- Widths: the counter and data paths are 16-bit with modulo arithmetic; the UART carries 8-bit data only, and upper writedata bits to 0xFF0/0xFF1 are ignored.

Decomposition:
- Package mu0_mem_pkg holds:
  - address constants: ADDR_LED=12'hFF0, ADDR_TXD=12'hFF1, ADDR_STAT=12'hFF2, ADDR_CNT=12'hFF3;
  - status bit indices;
  - the TX state enum (IDLE/START/DATA/STOP).
- One sub-module, mu0_uart_tx, contains the FIFO and serializer, with ports sysclk, reset, push, din[7:0], full, empty, busy, ovf_clr, ovf, uart_tx.
- Address decode, RAM, LED register and counter stay in mu0_mem_io.

Test Plan:
- Reset then read all I/O addresses: release reset with memRW=0 -> 0xFF0 reads 0x0000, 0xFF2 reads 0x0004 (empty), 0xFF1 reads 0, uart_tx=1.
- RAM write/read: write 0xBEEF to 0x123 -> an immediate read of 0x123 returns 0xBEEF; a read of 0xFF8 returns 0.
- UART single byte with BAUD_DIV=4: write 0x00A5 to 0xFF1 -> uart_tx is low for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4. Status bit3 is set during the frame and clears after STOP.
- FIFO overflow with BAUD_DIV=4: five back-to-back writes of 0x01..0x05 to 0xFF1 on consecutive cycles.
  - 0x01 is popped into the serializer the cycle after its push.
  - 0x02..0x05 then fill the FIFO, so status reads full=1, ovf=0.
  - A sixth write of 0x06 is dropped and sets ovf (status 0x001A).
  - A write to 0xFF2 clears ovf.
  - Exactly 5 frames (0x01..0x05) appear on the line.
- Counter: write 0x FFFE to 0xFF3 -> the next cycle reads 0xFFFF, then 0x0000 (wrap).
- Mid-frame reset: assert reset during bit 3 of a frame with 2 bytes queued -> uart_tx=1 the next cycle, status reads 0x0004, and no further frames appear.
